// File: rtl/ex_result_buffer_pkg.sv
// Shared definitions for the execute-stage result buffer: branch funct3
// encodings and the buffer occupancy states.
package ex_result_buffer_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } buf_state_t;

endpackage

// File: rtl/ex_result_buffer_branch_cond.sv
// RISC-V conditional branch resolution from FU flags (N = result sign bit).
module branch_cond
  import ex_result_buffer_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       z,
  input  logic       c,
  input  logic       v,
  input  logic       n,
  output logic       taken_c
);

  always_comb begin
    taken_c = 1'b0;
    case (funct3)
      F3_BEQ:  taken_c = z;
      F3_BNE:  taken_c = ~z;
      F3_BLT:  taken_c = n ^ v;
      F3_BGE:  taken_c = ~(n ^ v);
      F3_BLTU: taken_c = ~c;
      F3_BGEU: taken_c = c;
      default: taken_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_result_buffer.sv
// Execute-stage output buffer: 2-entry skid buffer between the FU and the
// memory/writeback stage, with branch resolution at capture and flush.
module ex_result_buffer
  import ex_result_buffer_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_z,
  input  logic              in_c,
  input  logic              in_v,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_we,
  input  logic              in_is_branch,
  input  logic [2:0]        in_funct3,
  input  logic [DATA_W-1:0] in_target,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_we,
  output logic              out_taken,
  output logic [DATA_W-1:0] out_target,
  output logic              out_redirect
);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [RD_W-1:0]   rd;
    logic              we;
    logic              taken;
    logic [DATA_W-1:0] target;
  } rec_t;

  buf_state_t state, state_next;
  rec_t       main_q, skid_q, in_rec;
  logic       cond_taken;
  logic       accept, release_c;
  logic       load_main_in, load_main_skid, load_skid;
  logic       redirect_q;

  branch_cond u_branch_cond (
    .funct3  (in_funct3),
    .z       (in_z),
    .c       (in_c),
    .v       (in_v),
    .n       (in_result[DATA_W-1]),
    .taken_c (cond_taken)
  );

  // Branch records never write the register file.
  always_comb begin
    in_rec        = '0;
    in_rec.result = in_result;
    in_rec.rd     = in_rd;
    in_rec.we     = in_we & ~in_is_branch;
    in_rec.taken  = in_is_branch & cond_taken;
    in_rec.target = in_target;
  end

  assign in_ready  = (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign release_c = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_next;
  end

  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            load_main_in = 1'b1;
            state_next   = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && release_c) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            load_skid  = 1'b1;
            state_next = ST_FULL;
          end else if (release_c) begin
            state_next = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (release_c) begin
            load_main_skid = 1'b1;
            state_next     = ST_ONE;
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  // Data only moves on a load; a flushed release still raises its redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      redirect_q <= 1'b0;
    end else begin
      if (load_main_in)        main_q <= in_rec;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_rec;
      redirect_q <= release_c & main_q.taken;
    end
  end

  assign out_result   = main_q.result;
  assign out_rd       = main_q.rd;
  assign out_we       = main_q.we;
  assign out_taken    = main_q.taken;
  assign out_target   = main_q.target;
  assign out_redirect = redirect_q;

endmodule

// File: doc/ex_result_buffer.md
Name: ex_result_buffer

Overview:
Execute-stage output buffer that sits directly downstream of the function unit. It captures the FU result and Z/C/V flags plus destination/control sideband, resolves the RISC-V branch condition from the flags, and presents a registered, valid/ready-handshaked record to the memory/writeback stage. A 2-entry skid buffer decouples FU timing from downstream stalls, and a synchronous flush squashes in-flight records on redirect.

Parameters:
DATA_W, 32, datapath and result width
RD_W, 5, destination register index width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
in_valid  in  1  FU record valid
in_ready  out  1  buffer can accept; equals NOT skid_valid
in_result  in  DATA_W  FU Result
in_z  in  1  FU zero flag
in_c  in  1  FU carry flag; 1 = no borrow on A-B
in_v  in  1  FU signed overflow flag
in_rd  in  RD_W  destination register
in_we  in  1  register write enable
in_is_branch  in  1  record is a conditional branch
in_funct3  in  3  branch funct3
in_target  in  DATA_W  branch target address
flush  in  1  squash all held records
out_valid  out  1  output record valid
out_ready  in  1  downstream accepts
out_result  out  DATA_W  registered result
out_rd  out  RD_W  registered rd
out_we  out  1  registered write enable; 0 for branches
out_taken  out  1  branch resolved taken
out_target  out  DATA_W  registered target
out_redirect  out  1  one-cycle pulse: taken branch handed off

Behaviour:
- Reset (rst=1 at edge): out_valid=0, out_result=0, out_rd=0, out_we=0, out_taken=0, out_target=0, out_redirect=0, skid empty. in_ready=1 from the first cycle after reset.
- Storage: main register (drives outputs) and skid register. States: EMPTY (main invalid), ONE (main valid, skid empty), FULL (both valid).
- Accept = in_valid & in_ready. Release = out_valid & out_ready.
- EMPTY: accept -> load main, go ONE. Latency in-to-out is 1 cycle.
- ONE: accept & release -> main reloaded from input, stay ONE. Accept only -> input to skid, go FULL. Release only -> EMPTY.
- FULL: in_ready=0. Release -> skid moves to main, go ONE. No release -> hold.
- Records stay in order and are never dropped or duplicated except by flush.
- Branch resolve at capture with N=in_result[DATA_W-1]: 000 BEQ taken=Z; 001 BNE ~Z; 100 BLT N^V; 101 BGE ~(N^V); 110 BLTU ~C; 111 BGEU C; 010/011 taken=0. in_is_branch=0 -> taken=0. A branch record forces stored we=0.
- out_redirect = release & out_taken, registered; it pulses the cycle after the handoff and lasts exactly 1 cycle.
- Flush (sync, priority over everything except rst): clears main and skid valid. A same-cycle input is discarded. out_valid=0 next cycle and the state goes EMPTY. A same-cycle release still counts as consumed, and its redirect pulse is still issued.
- Data registers update only on load, so outputs are stable while out_valid & ~out_ready.
- rst mid-operation discards all records, including a FULL buffer.

Decomposition:
- Shared package: branch funct3 constants (BEQ, BNE, BLT, BGE, BLTU, BGEU) and the state encoding EMPTY/ONE/FULL.
- Sub-module: branch_cond, a combinational unit taking funct3, Z, C, V and N and returning taken. It is reused by any later branch unit.

Test Plan:
- Single record: result=0x0000_002A, rd=5, we=1, out_ready=1 -> 1 cycle later out_valid=1, out_result=0x2A, out_rd=5. Next cycle out_valid=0.
- Back-pressure: out_ready=0, send 3 records 0x1, 0x2, 0x3 on consecutive cycles -> in_ready drops after the 2nd and record 3 is held by the source. Raise out_ready -> outputs 0x1, 0x2, 0x3 in order with no loss.
- Branch conditions: A=5, B=7, FU gives Z=0, C=0, V=0, result=0xFFFF_FFFE. Expect taken for BNE, BLT, BLTU; not taken for BEQ, BGE, BGEU. Expect out_we=0.
- Signed overflow: 0x8000_0000 - 1 gives V=1, N=0, C=1 -> BLT taken, BGEU taken. funct3=010 -> taken=0.
- Redirect: taken BEQ with target 0x0000_0100 released -> out_redirect=1 for exactly 1 cycle and out_target=0x100.
- Flush in FULL with a same-cycle in_valid -> next cycle out_valid=0, in_ready=1, and the flushed records never appear. Assert rst while FULL -> all outputs 0 next cycle.
